// File: rtl/cr_tlvp_ord_mrg.sv
// rtl/cr_tlvp_ord_mrg.sv - ordered merge of PT and USR TLV streams; optional resync via CR_TLVP_ORD_MRG_RESYNC_EN
module cr_tlvp_ord_mrg #(
  parameter int DATA_W = 64,
  parameter int ORD_W  = 8,
  parameter int TYPE_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2**TYPE_W-1:0] rep_mask,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [DATA_W-1:0]    pt_data,
  input  logic [TYPE_W-1:0]    pt_typen,
  input  logic [ORD_W-1:0]     pt_ordern,
  input  logic                 pt_eot,
  input  logic                 pt_tlast,
  input  logic                 usr_valid,
  output logic                 usr_ready,
  input  logic [DATA_W-1:0]    usr_data,
  input  logic [TYPE_W-1:0]    usr_typen,
  input  logic [ORD_W-1:0]     usr_ordern,
  input  logic                 usr_eot,
  input  logic                 usr_tlast,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [TYPE_W-1:0]    out_typen,
  output logic [ORD_W-1:0]     out_ordern,
  output logic                 out_eot,
  output logic                 out_tlast,
  output logic                 ord_err
);

  typedef enum logic [1:0] {SEL, FWD_PT, FWD_USR, DROP_PT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ORD_W-1:0] exp_ord;
  logic [ORD_W-1:0] resync_ord;
  logic             can_load;
  logic             pt_match;
  logic             usr_match;
  logic             pt_rep;
  logic             fwd_pt;
  logic             fwd_usr;
  logic             fwd_eot;
  logic             fwd_tlast;
  logic             resync;

  assign can_load   = !out_valid || out_ready;
  assign pt_match   = pt_valid && (pt_ordern == exp_ord);
  assign usr_match  = usr_valid && (usr_ordern == exp_ord);
  assign pt_rep     = rep_mask[pt_typen];
  assign fwd_eot    = (fwd_pt && pt_eot) || (fwd_usr && usr_eot);
  assign fwd_tlast  = fwd_pt ? pt_tlast : usr_tlast;
  assign resync_ord = (pt_ordern < usr_ordern) ? pt_ordern : usr_ordern;

`ifdef CR_TLVP_ORD_MRG_RESYNC_EN
  // two valid heads that both miss can never progress; restart from the older of the two
  assign resync = (state == SEL) && pt_valid && usr_valid && !pt_match && !usr_match;

  // error pulse lines up with the cycle exp_ord takes the resync value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ord_err <= 1'b0;
    else        ord_err <= resync;
  end
`else
  assign resync  = 1'b0;
  assign ord_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEL;
    else        state <= state_nxt;
  end

  // next-state: SEL picks the stream owning exp_ord, forwarding states run to eot
  always_comb begin
    state_nxt = state;
    case (state)
      SEL: begin
        if (pt_match && !pt_rep)     state_nxt = (fwd_pt && pt_eot) ? SEL : FWD_PT;
        else if (pt_match && pt_rep) state_nxt = usr_match ? DROP_PT : SEL;
        else if (usr_match)          state_nxt = (fwd_usr && usr_eot) ? SEL : FWD_USR;
      end
      FWD_PT:  if (fwd_pt && pt_eot)    state_nxt = SEL;
      FWD_USR: if (fwd_usr && usr_eot)  state_nxt = SEL;
      DROP_PT: if (pt_valid && pt_eot)  state_nxt = FWD_USR;
      default: state_nxt = SEL;
    endcase
  end

  // outputs: SEL forwards the first word itself so back-to-back TLVs leave no bubble
  always_comb begin
    fwd_pt  = 1'b0;
    fwd_usr = 1'b0;
    case (state)
      SEL: begin
        if (pt_match && !pt_rep)  fwd_pt  = can_load;
        else if (usr_match && !pt_match) fwd_usr = can_load;
      end
      FWD_PT:  fwd_pt  = pt_valid && can_load;
      FWD_USR: fwd_usr = usr_valid && can_load;
      default: ;
    endcase
    pt_ready  = fwd_pt || ((state == DROP_PT) && pt_valid);
    usr_ready = fwd_usr;
  end

  // expected order number: advance per TLV, restart per frame, or resync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       exp_ord <= ORD_W'(1);
    else if (resync)  exp_ord <= resync_ord;
    else if (fwd_eot) exp_ord <= fwd_tlast ? ORD_W'(1) : ORD_W'(exp_ord + 1'b1);
  end

  // single-stage output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_typen  <= '0;
      out_ordern <= '0;
      out_eot    <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (fwd_pt) begin
      out_valid  <= 1'b1;
      out_data   <= pt_data;
      out_typen  <= pt_typen;
      out_ordern <= pt_ordern;
      out_eot    <= pt_eot;
      out_tlast  <= pt_tlast;
    end else if (fwd_usr) begin
      out_valid  <= 1'b1;
      out_data   <= usr_data;
      out_typen  <= usr_typen;
      out_ordern <= usr_ordern;
      out_eot    <= usr_eot;
      out_tlast  <= usr_tlast;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
